pad_trigger_generator: RTL
==========================

// Module: pad_trigger_generator
// PURPOSE
//  Downstream consumer of the windowed 104-bit pad hit map from the window-sync stage.
//  - Counts asserted pads with a 2-stage pipelined popcount and compares the count to a programmable threshold.
//  - Issues a one-cycle trigger pulse on a qualifying map, then holds the hit map and count for readout on a valid/ready handshake.
//  - Enforces a programmable deadtime after each trigger.
// PARAMETERS
//  PAD_W       104  pad hit map width
//  CNT_W       7    hit count width, ceil(log2(PAD_W+1))
//  DT_W        8    deadtime counter width
//  TRIG_CNT_W  16   trigger / drop counter width
// PORTS
//  clk            in   1           system clock
//  rst_n          in   1           async reset, active low
//  pad_data_syn   in   PAD_W       windowed pad hit map
//  pad_data_valid in   1           qualifies pad_data_syn
//  pad_hit_clear  in   1           sync flush of pipeline and deadtime
//  trig_enable    in   1           arms the generator
//  threshold      in   CNT_W       min hit count to trigger; 0 = never trigger
//  deadtime       in   DT_W        cycles spent in DEAD after the readout handshake
//  trigger_out    out  1           1-cycle trigger pulse
//  trig_valid     out  1           hit map/count available for readout
//  trig_ready     in   1           readout accepts the map/count
//  trig_hit_map   out  PAD_W       captured hit map
//  trig_hit_cnt   out  CNT_W       captured hit count
//  trig_count     out  TRIG_CNT_W  accepted triggers, wraps
//  drop_count     out  TRIG_CNT_W  qualifying maps lost, saturates
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, FSM=IDLE, pipeline valids 0, deadtime counter 0.
//  - Pipeline:
//    - Edge E, pad_data_valid=1: S1 registers map + 13 partial 4-bit sums (8 pads each).
//    - Edge E+1: S2 registers total count, map, and qual = (count>=threshold)&&(threshold!=0).
//    - Edge E+2: FSM acts on S2; trigger_out and trig_valid rise here.
//    - pad_data_valid=0 at E: S1 valid=0, and no decision is made 2 edges later.
//  - Count arithmetic: unsigned, CNT_W bits; 104 fits, no overflow.
//  - FSM states:
//    - IDLE: trig_enable=1 -> ARMED.
//    - ARMED:
//      - S2 valid && qual -> HOLD; pulse trigger_out, capture map/count, trig_valid=1, trig_count++.
//      - trig_enable=0 -> IDLE.
//    - HOLD:
//      - trig_valid && trig_ready -> trig_valid=0 at the next edge; map/count keep their values.
//        Then: deadtime!=0 -> DEAD with counter loaded to deadtime; deadtime=0 -> ARMED, or IDLE if !trig_enable.
//      - map/count are stable while trig_valid && !trig_ready.
//    - DEAD: counter decrements each cycle; at 1 -> ARMED, or IDLE if !trig_enable.
//  - Qualifying S2 result in HOLD or DEAD: drop_count++ (saturating); no pulse.
//  - Qualifying S2 result in IDLE: ignored, not counted.
//  - Simultaneous events:
//    - Handshake and a new qualifying result in the same cycle: the new result is dropped.
//  - pad_hit_clear=1:
//    - Zeroes S1/S2 valids.
//    - DEAD -> ARMED, or IDLE if !trig_enable.
//    - HOLD and all counters unaffected.
//  - trig_enable dropping during HOLD: the handshake completes normally; exit goes to IDLE.
//  - Reset mid-HOLD: trig_valid drops immediately, async.
// CONFIGURATION
//  PAD_TRIG_MASK_EN:
//    - Defined: adds input pad_mask[PAD_W-1:0].
//    - S1 popcounts and captures pad_data_syn & ~pad_mask; masked pads are neither counted nor reported.
//    - Not defined: port absent; all pads used.
// STRUCTURE
//  - Shared package pad_trig_pkg:
//    - PAD_W, CNT_W, DT_W.
//    - FSM state enum {IDLE, ARMED, HOLD, DEAD}.
//  - Sub-module pad_popcount: the 2-stage pipelined popcount with valid pass-through, PAD_W-parametric.
//  - FSM, capture registers and counters live in the top level.
// TESTING
//  1. thr=3, deadtime=0, ready=1; map with bits 0,50,103 set:
//     -> trigger_out pulses 2 edges after sampling, cnt=3, map echoed, trig_count=1.
//  2. thr=4, same map -> no trigger; all-ones map -> cnt=104, trigger.
//  3. ready=0 for 10 cycles, 3 more qualifying maps -> drop_count=3; map/count stable until ready.
//  4. deadtime=5, qualifying map every cycle:
//     -> triggers spaced by 5 cycles in DEAD, plus HOLD and pipeline cycles; drops counted.
//  5. pad_hit_clear during DEAD -> ARMED next edge; rst_n low mid-HOLD -> all outputs 0 at once.
//  6. MASK_EN defined, mask bit 50 set, thr=3, map {0,50,103} -> no trigger.

Source files
------------

// File: rtl/pad_trig_pkg.sv
// Shared widths and FSM state encoding for the pad trigger generator.
package pad_trig_pkg;

  localparam int unsigned PAD_W      = 104;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned DT_W       = 8;
  localparam int unsigned TRIG_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2,
    DEAD  = 2'd3
  } state_t;

endpackage

// File: rtl/pad_popcount.sv
// Two-stage pipelined popcount of the pad hit map with valid pass-through
// and threshold qualification registered alongside the total count.
module pad_popcount #(
  parameter int unsigned PAD_W = 104,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [PAD_W-1:0] in_map,
  input  logic [CNT_W-1:0] threshold,
  output logic             s2_valid,
  output logic [PAD_W-1:0] s2_map,
  output logic [CNT_W-1:0] s2_cnt,
  output logic             s2_qual
);

  localparam int unsigned GRP_N   = (PAD_W + 7) / 8;
  localparam int unsigned PAD_EXT = GRP_N * 8;

  logic [PAD_EXT-1:0] map_ext;
  logic [3:0]         part_d [GRP_N];
  logic [3:0]         s1_part [GRP_N];
  logic               s1_valid;
  logic [PAD_W-1:0]   s1_map;
  logic [CNT_W-1:0]   total;

  // Map is zero-extended to whole 8-pad groups so the last group needs no special case.
  always_comb begin
    map_ext = '0;
    map_ext[PAD_W-1:0] = in_map;
    for (int unsigned g = 0; g < GRP_N; g++) begin
      part_d[g] = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        part_d[g] = part_d[g] + 4'(map_ext[g*8 + b]);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int unsigned g = 0; g < GRP_N; g++) begin
      total = total + CNT_W'(s1_part[g]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_map   <= '0;
      for (int unsigned g = 0; g < GRP_N; g++) begin
        s1_part[g] <= '0;
      end
      s2_valid <= 1'b0;
      s2_map   <= '0;
      s2_cnt   <= '0;
      s2_qual  <= 1'b0;
    end else begin
      s1_valid <= in_valid && !clear;
      s2_valid <= s1_valid && !clear;
      if (in_valid) begin
        s1_map <= in_map;
        for (int unsigned g = 0; g < GRP_N; g++) begin
          s1_part[g] <= part_d[g];
        end
      end
      if (s1_valid) begin
        s2_map  <= s1_map;
        s2_cnt  <= total;
        s2_qual <= (total >= threshold) && (threshold != '0);
      end
    end
  end

endmodule

// File: rtl/pad_trigger_generator.sv
// Pad-count trigger with readout handshake, deadtime and trigger/drop counters.
// Optional PAD_TRIG_MASK_EN adds a pad_mask input that removes pads from count and map.
module pad_trigger_generator
  import pad_trig_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PAD_W-1:0]      pad_data_syn,
  input  logic                  pad_data_valid,
  input  logic                  pad_hit_clear,
  input  logic                  trig_enable,
  input  logic [CNT_W-1:0]      threshold,
  input  logic [DT_W-1:0]       deadtime,
`ifdef PAD_TRIG_MASK_EN
  input  logic [PAD_W-1:0]      pad_mask,
`endif
  output logic                  trigger_out,
  output logic                  trig_valid,
  input  logic                  trig_ready,
  output logic [PAD_W-1:0]      trig_hit_map,
  output logic [CNT_W-1:0]      trig_hit_cnt,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [TRIG_CNT_W-1:0] drop_count
);

  state_t           state;
  logic [DT_W-1:0]  dead_cnt;
  logic [PAD_W-1:0] pad_used;
  logic             s2_valid;
  logic [PAD_W-1:0] s2_map;
  logic [CNT_W-1:0] s2_cnt;
  logic             s2_qual;
  logic             hit;
  state_t           rearm_state;

`ifdef PAD_TRIG_MASK_EN
  assign pad_used = pad_data_syn & ~pad_mask;
`else
  assign pad_used = pad_data_syn;
`endif

  pad_popcount #(
    .PAD_W (PAD_W),
    .CNT_W (CNT_W)
  ) u_popcount (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pad_hit_clear),
    .in_valid  (pad_data_valid),
    .in_map    (pad_used),
    .threshold (threshold),
    .s2_valid  (s2_valid),
    .s2_map    (s2_map),
    .s2_cnt    (s2_cnt),
    .s2_qual   (s2_qual)
  );

  assign hit         = s2_valid && s2_qual;
  assign rearm_state = trig_enable ? ARMED : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dead_cnt     <= '0;
      trigger_out  <= 1'b0;
      trig_valid   <= 1'b0;
      trig_hit_map <= '0;
      trig_hit_cnt <= '0;
      trig_count   <= '0;
      drop_count   <= '0;
    end else begin
      trigger_out <= 1'b0;
      // Qualifying maps that arrive while busy are lost; drop_count sticks at all-ones.
      if (hit && (state == HOLD || state == DEAD) && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (trig_enable) state <= ARMED;
        end
        ARMED: begin
          if (hit) begin
            state        <= HOLD;
            trigger_out  <= 1'b1;
            trig_valid   <= 1'b1;
            trig_hit_map <= s2_map;
            trig_hit_cnt <= s2_cnt;
            trig_count   <= trig_count + 1'b1;
          end else if (!trig_enable) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (trig_ready) begin
            trig_valid <= 1'b0;
            if (deadtime != '0) begin
              state    <= DEAD;
              dead_cnt <= deadtime;
            end else begin
              state <= rearm_state;
            end
          end
        end
        DEAD: begin
          if (pad_hit_clear || dead_cnt == DT_W'(1)) begin
            state    <= rearm_state;
            dead_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
